// File: rtl/csr_ex_ctrl_if.sv
// csr_ex_ctrl_if: writeback, CSR and fetch-redirect signals of the
// exception/interrupt commit sequencer. The slave modport is the
// sequencer's view; the master modport is the surrounding pipeline.
interface csr_ex_ctrl_if;
    // writeback side
    logic        wb_valid;
    logic        wb_ex;
    logic [7:0]  wb_ecode;
    logic        wb_esubcode;
    logic        wb_ertn;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    // CSR side
    logic        has_int;
    logic [31:0] ex_entryPC;
    logic [31:0] new_pc;
    logic        ex_en;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        ertn_flush;
    // pipeline control and fetch redirect
    logic        flush_pipe;
    logic        commit_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output wb_valid, wb_ex, wb_ecode, wb_esubcode, wb_ertn, wb_pc, wb_vaddr,
        output has_int, ex_entryPC, new_pc, redirect_ready,
        input  ex_en, ecode, esubcode, pc, vaddr, ertn_flush,
        input  flush_pipe, commit_stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  wb_valid, wb_ex, wb_ecode, wb_esubcode, wb_ertn, wb_pc, wb_vaddr,
        input  has_int, ex_entryPC, new_pc, redirect_ready,
        output ex_en, ecode, esubcode, pc, vaddr, ertn_flush,
        output flush_pipe, commit_stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_ex_ctrl.sv
// csr_ex_ctrl: exception/interrupt commit sequencer between writeback and
// the CSR file. Accepts one event (interrupt > exception > ertn) in IDLE,
// strobes the CSR for one cycle while flushing, then holds a redirect to
// fetch until it is accepted.
// Build option: define CSR_EXCTRL_INT_EN to compile in the interrupt path
// and the post-ertn interrupt holdoff window; without it has_int is ignored.
module csr_ex_ctrl #(
    parameter int INT_HOLDOFF = 2,
    parameter int HOLD_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    csr_ex_ctrl_if.slave  bus
);

`ifdef CSR_EXCTRL_INT_EN
    typedef enum logic [1:0] {IDLE, CAPTURE, REDIRECT, HOLDOFF} state_t;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, REDIRECT} state_t;
`endif

    // A holdoff that the counter cannot represent is a build-time error.
    if (INT_HOLDOFF < 0 || INT_HOLDOFF >= (1 << HOLD_W)) begin : g_bad_holdoff
        $error("INT_HOLDOFF does not fit in HOLD_W bits");
    end

    state_t      state;
    logic        kind_ertn;
    logic        ex_en;
    logic        ertn_flush;
    logic        flush_pipe;
    logic        commit_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
`ifdef CSR_EXCTRL_INT_EN
    logic [HOLD_W-1:0] hold_cnt;
`endif

    logic take_int;
    logic take_ex;
    logic take_ertn;
    logic accept;

    // Event arbitration: interrupt beats exception beats ertn; only IDLE
    // accepts, which also masks interrupts in every other state.
    always_comb begin
        take_int = 1'b0;
`ifdef CSR_EXCTRL_INT_EN
        take_int = bus.has_int;
`endif
        take_ex   = ~take_int & bus.wb_ex;
        take_ertn = ~take_int & ~bus.wb_ex & bus.wb_ertn;
        accept    = (state == IDLE) & bus.wb_valid & (take_int | take_ex | take_ertn);
    end

    // Sequencer FSM with registered strobes, redirect and captured payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            kind_ertn      <= 1'b0;
            ex_en          <= 1'b0;
            ertn_flush     <= 1'b0;
            flush_pipe     <= 1'b0;
            commit_stall   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            ecode          <= 8'h0;
            esubcode       <= 1'b0;
            pc             <= 32'h0;
            vaddr          <= 32'h0;
`ifdef CSR_EXCTRL_INT_EN
            hold_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= CAPTURE;
                        kind_ertn    <= take_ertn;
                        ex_en        <= ~take_ertn;
                        ertn_flush   <= take_ertn;
                        flush_pipe   <= 1'b1;
                        commit_stall <= 1'b1;
                        if (take_int) begin
                            ecode    <= 8'h00;
                            esubcode <= 1'b0;
                            pc       <= bus.wb_pc;
                            vaddr    <= 32'h0;
                        end else if (take_ex) begin
                            ecode    <= bus.wb_ecode;
                            esubcode <= bus.wb_esubcode;
                            pc       <= bus.wb_pc;
                            vaddr    <= bus.wb_vaddr;
                        end
                    end
                end
                CAPTURE: begin
                    // new_pc is sampled here, before the CSR applies ertn.
                    ex_en          <= 1'b0;
                    ertn_flush     <= 1'b0;
                    flush_pipe     <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= kind_ertn ? bus.new_pc : bus.ex_entryPC;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        redirect_valid <= 1'b0;
                        commit_stall   <= 1'b0;
                        state          <= IDLE;
`ifdef CSR_EXCTRL_INT_EN
                        if (kind_ertn && (INT_HOLDOFF > 0)) begin
                            state    <= HOLDOFF;
                            hold_cnt <= HOLD_W'(INT_HOLDOFF);
                        end
`endif
                    end
                end
`ifdef CSR_EXCTRL_INT_EN
                HOLDOFF: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ex_en          = ex_en;
    assign bus.ertn_flush     = ertn_flush;
    assign bus.flush_pipe     = flush_pipe;
    assign bus.commit_stall   = commit_stall;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.ecode          = ecode;
    assign bus.esubcode       = esubcode;
    assign bus.pc             = pc;
    assign bus.vaddr          = vaddr;

endmodule

// File: tb/tb_csr_ex_ctrl.sv
// tb_csr_ex_ctrl: directed bench for csr_ex_ctrl with a scoreboard of
// expected CSR strobes and redirect targets.
module tb_csr_ex_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_ex_ctrl_if bus ();
    csr_ex_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        ertn;
        logic [7:0]  ecode;
        logic        esub;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [31:0] target;
    } exp_t;

    exp_t        q[$];
    logic [31:0] cur_target = 32'h0;
    int          checks  = 0;
    int          errors  = 0;
    int          strobes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic ertn, input logic [7:0] ec, input logic es,
                        input logic [31:0] p, input logic [31:0] va, input logic [31:0] tgt);
        exp_t e;
        e.ertn = ertn; e.ecode = ec; e.esub = es; e.pc = p; e.vaddr = va; e.target = tgt;
        q.push_back(e);
    endtask

    // Scoreboard: each CSR strobe pops one expectation; each redirect
    // handshake is compared with the target of the last popped event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ex_en || bus.ertn_flush) begin
                strobes++;
                if (q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    cur_target = e.target;
                    check("strobe_ertn_flush", 32'(bus.ertn_flush), 32'(e.ertn));
                    check("strobe_ex_en", 32'(bus.ex_en), 32'(!e.ertn));
                    check("strobe_flush_pipe", 32'(bus.flush_pipe), 32'd1);
                    check("strobe_commit_stall", 32'(bus.commit_stall), 32'd1);
                    if (!e.ertn) begin
                        check("ecode", 32'(bus.ecode), 32'(e.ecode));
                        check("esubcode", 32'(bus.esubcode), 32'(e.esub));
                        check("era_pc", bus.pc, e.pc);
                        check("badv", bus.vaddr, e.vaddr);
                    end
                end
            end
            if (bus.redirect_valid && bus.redirect_ready)
                check("redirect_pc_at_accept", bus.redirect_pc, cur_target);
        end
    end

    task automatic clear_wb();
        bus.wb_valid = 1'b0; bus.wb_ex = 1'b0; bus.wb_ertn = 1'b0; bus.has_int = 1'b0;
    endtask

    // One-cycle writeback presentation, sampled at the following edge.
    task automatic drive(input logic v, input logic ex, input logic ertn, input logic intr,
                         input logic [7:0] ec, input logic es, input logic [31:0] p,
                         input logic [31:0] va);
        @(posedge clk); #1;
        bus.wb_valid = v; bus.wb_ex = ex; bus.wb_ertn = ertn; bus.has_int = intr;
        bus.wb_ecode = ec; bus.wb_esubcode = es; bus.wb_pc = p; bus.wb_vaddr = va;
        @(posedge clk); #1;
        clear_wb();
    endtask

    // Wait (bounded) for redirect_valid, keep ready low for 'stall' cycles
    // checking stability, then optionally accept. Returns #1 after the
    // accepting edge.
    task automatic handshake(input int stall, input logic [31:0] tgt, input logic rel);
        bit found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.redirect_valid) found = 1;
        end
        check("redirect_seen", 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < stall; i++) begin
                if (i > 0) @(negedge clk);
                check("wait_valid", 32'(bus.redirect_valid), 32'd1);
                check("wait_pc", bus.redirect_pc, tgt);
                check("wait_stall", 32'(bus.commit_stall), 32'd1);
            end
            if (rel) begin
                @(posedge clk); #1 bus.redirect_ready = 1'b1;
                @(posedge clk); #1 bus.redirect_ready = 1'b0;
            end
        end
    endtask

    initial begin
        int s0;
        clear_wb();
        bus.wb_ecode = 8'h0; bus.wb_esubcode = 1'b0; bus.wb_pc = 32'h0; bus.wb_vaddr = 32'h0;
        bus.ex_entryPC = 32'h1C00_8000; bus.new_pc = 32'h1C00_0104; bus.redirect_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ex_en", 32'(bus.ex_en), 32'd0);
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_commit_stall", 32'(bus.commit_stall), 32'd0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_ecode", 32'(bus.ecode), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        rst = 1'b0;

        // exception with 3 cycles of redirect back-pressure
        push(1'b0, 8'h0B, 1'b1, 32'h1C00_0100, 32'hDEAD_BEEF, 32'h1C00_8000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b1, 32'h1C00_0100, 32'hDEAD_BEEF);
        handshake(3, 32'h1C00_8000, 1'b1);
        @(negedge clk);
        check("post_ex_valid", 32'(bus.redirect_valid), 32'd0);
        check("post_ex_stall", 32'(bus.commit_stall), 32'd0);
        check("payload_held_pc", bus.pc, 32'h1C00_0100);
        check("strobes_after_ex", 32'(strobes), 32'd1);

        // ertn, then interrupt holdoff
        push(1'b1, 8'h0, 1'b0, 32'h0, 32'h0, 32'h1C00_0104);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, 32'h1C00_0500, 32'h0);
        handshake(1, 32'h1C00_0104, 1'b1);
`ifdef CSR_EXCTRL_INT_EN
        bus.wb_valid = 1'b1; bus.has_int = 1'b1; bus.wb_pc = 32'h1C00_0104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("holdoff_no_int", 32'(bus.ex_en), 32'd0);
        end
        push(1'b0, 8'h00, 1'b0, 32'h1C00_0104, 32'h0, 32'h1C00_8000);
        @(posedge clk); #1 clear_wb();
        handshake(1, 32'h1C00_8000, 1'b1);
        check("strobes_after_int", 32'(strobes), 32'd3);

        // interrupt + exception + ertn together
        push(1'b0, 8'h00, 1'b0, 32'h1C00_0200, 32'h0, 32'h1C00_8000);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 32'h1C00_0200, 32'h1234_5678);
        handshake(1, 32'h1C00_8000, 1'b1);
`else
        // has_int alone is ignored in this build
        s0 = strobes;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h0, 1'b0, 32'h1C00_0200, 32'h0);
        repeat (2) @(negedge clk);
        check("int_ignored_valid", 32'(bus.redirect_valid), 32'd0);
        check("int_ignored_strobes", 32'(strobes), 32'(s0));
`endif

        // exception and ertn together: exception wins
        push(1'b0, 8'h09, 1'b0, 32'h1C00_0300, 32'h0000_0040, 32'h1C00_8000);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 32'h1C00_0300, 32'h0000_0040);
        handshake(1, 32'h1C00_8000, 1'b1);

        // wb_ex without wb_valid: nothing happens
        s0 = strobes;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 32'h1C00_0400, 32'h0);
        repeat (2) @(negedge clk);
        check("novalid_redirect", 32'(bus.redirect_valid), 32'd0);
        check("novalid_strobes", 32'(strobes), 32'(s0));

        // wb_ex pulses during REDIRECT are ignored
        s0 = strobes;
        bus.ex_entryPC = 32'h1C00_9000;
        push(1'b0, 8'h03, 1'b0, 32'h1C00_0600, 32'h0, 32'h1C00_9000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 32'h1C00_0600, 32'h0);
        handshake(1, 32'h1C00_9000, 1'b0);
        @(posedge clk); #1;
        bus.wb_valid = 1'b1; bus.wb_ex = 1'b1; bus.wb_ecode = 8'h22; bus.wb_pc = 32'h0000_AAAA;
        repeat (2) @(posedge clk);
        #1 clear_wb();
        @(negedge clk);
        check("redirect_pulse_pc", bus.pc, 32'h1C00_0600);
        check("redirect_pulse_ecode", 32'(bus.ecode), 32'h03);
        handshake(1, 32'h1C00_9000, 1'b1);
        repeat (3) @(negedge clk);
        check("one_strobe_per_event", 32'(strobes), 32'(s0 + 1));

        // async reset while waiting in REDIRECT
        push(1'b0, 8'h05, 1'b0, 32'h1C00_0700, 32'h0, 32'h1C00_9000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 32'h1C00_0700, 32'h0);
        handshake(1, 32'h1C00_9000, 1'b0);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("arst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("arst_commit_stall", 32'(bus.commit_stall), 32'd0);
        check("arst_pc", bus.pc, 32'h0);
        @(negedge clk) rst = 1'b0;
        push(1'b0, 8'h07, 1'b1, 32'h1C00_0800, 32'h0000_0100, 32'h1C00_9000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 32'h1C00_0800, 32'h0000_0100);
        handshake(1, 32'h1C00_9000, 1'b1);
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
